interconnect_nport: RTL and testbench

INTERCONNECT_NPORT -- requirements
Module: interconnect_nport

---
 rtl/interconnect_nport.sv | 216 +++++++++++++++++++++
 tb/tb_interconnect_nport.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/interconnect_nport.sv
// -----------------------------------------------------------------------------
// interconnect_nport
//
// Purpose: single-master to N-slave memory-mapped interconnect. One upstream
// request is sampled in IDLE and decoded against per-port base/mask pairs.
// It is then forwarded to the selected downstream port and held there until
// that port stops waiting or a timeout expires. The result is returned upstream
// in a one-cycle DONE window. Decode misses and read+write collisions complete
// without touching any downstream port.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   s_bus_addr/read/write/writedata/byteenable   upstream request (inputs)
//   s_bus_readdata/response/waitrequest          upstream completion (outputs)
//   m_bus_addr/read/write/writedata/byteenable   downstream request, slice i
//                                                belongs to port i (outputs)
//   m_bus_readdata/response/waitrequest          downstream completion (inputs)
// -----------------------------------------------------------------------------
module interconnect_nport #(
  parameter int                    N_PORTS        = 4,
  parameter logic [32*N_PORTS-1:0] BASE_LIST      = {32'h300, 32'h200, 32'h100, 32'h000},
  parameter logic [32*N_PORTS-1:0] MASK_LIST      = {4{32'hFFFF_FF00}},
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  // upstream slave side
  input  logic [31:0]            s_bus_addr,
  input  logic                   s_bus_read,
  input  logic                   s_bus_write,
  input  logic [31:0]            s_bus_writedata,
  input  logic [3:0]             s_bus_byteenable,
  output logic [31:0]            s_bus_readdata,
  output logic [1:0]             s_bus_response,
  output logic                   s_bus_waitrequest,
  // downstream master side
  output logic [32*N_PORTS-1:0]  m_bus_addr,
  output logic [N_PORTS-1:0]     m_bus_read,
  output logic [N_PORTS-1:0]     m_bus_write,
  output logic [32*N_PORTS-1:0]  m_bus_writedata,
  output logic [4*N_PORTS-1:0]   m_bus_byteenable,
  input  logic [32*N_PORTS-1:0]  m_bus_readdata,
  input  logic [2*N_PORTS-1:0]   m_bus_response,
  input  logic [N_PORTS-1:0]     m_bus_waitrequest
);

  localparam int          SEL_W       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t               state_q;
  logic [SEL_W-1:0]     sel_q;
  logic                 is_write_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           be_q;
  logic [N_PORTS-1:0]   rd_strobe_q;
  logic [N_PORTS-1:0]   wr_strobe_q;
  logic [15:0]          cnt_q;
  logic                 waitreq_q;
  logic [31:0]          rdata_q;
  logic [1:0]           resp_q;

  // ---------------------------------------------------------------------------
  // Address decode and per-port downstream fan-out
  // ---------------------------------------------------------------------------
  logic [N_PORTS-1:0] hit;
  logic [N_PORTS-1:0] hit_onehot;
  logic [SEL_W-1:0]   hit_sel;
  logic               any_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_port
      assign hit[gi] = ((s_bus_addr & MASK_LIST[32*gi +: 32]) == BASE_LIST[32*gi +: 32]);
      // Each slave sees only the offset inside its own window.
      assign m_bus_addr[32*gi +: 32]      = addr_q & ~MASK_LIST[32*gi +: 32];
      assign m_bus_writedata[32*gi +: 32] = wdata_q;
      assign m_bus_byteenable[4*gi +: 4]  = be_q;
    end
  endgenerate

  // Isolate the lowest set bit: overlapping windows go to the lowest index.
  assign hit_onehot = hit & (~hit + 1'b1);

  always_comb begin
    hit_sel = '0;
    any_hit = 1'b0;
    // Descending scan so the lowest hitting index is written last and wins.
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_sel = SEL_W'(i);
        any_hit = 1'b1;
      end
    end
  end

  // Mux of the selected port's completion signals.
  logic        sel_wait;
  logic [31:0] sel_rdata;
  logic [1:0]  sel_resp;

  always_comb begin
    sel_wait  = 1'b1;
    sel_rdata = '0;
    sel_resp  = RESP_OKAY;
    for (int i = 0; i < N_PORTS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_wait  = m_bus_waitrequest[i];
        sel_rdata = m_bus_readdata[32*i +: 32];
        sel_resp  = m_bus_response[2*i +: 2];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM; every upstream/downstream control output is a register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rd_strobe_q <= '0;
      wr_strobe_q <= '0;
      cnt_q       <= '0;
      waitreq_q   <= 1'b1;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          waitreq_q <= 1'b1;
          if (s_bus_read && s_bus_write) begin
            // Ambiguous direction: reject without any downstream activity.
            rdata_q   <= '0;
            resp_q    <= RESP_SLVERR;
            waitreq_q <= 1'b0;
            state_q   <= ST_DONE;
          end else if (s_bus_read || s_bus_write) begin
            if (any_hit) begin
              sel_q       <= hit_sel;
              is_write_q  <= s_bus_write;
              addr_q      <= s_bus_addr;
              wdata_q     <= s_bus_writedata;
              be_q        <= s_bus_byteenable;
              rd_strobe_q <= s_bus_read  ? hit_onehot : '0;
              wr_strobe_q <= s_bus_write ? hit_onehot : '0;
              cnt_q       <= 16'd1;
              state_q     <= ST_ACCESS;
            end else begin
              rdata_q   <= '0;
              resp_q    <= RESP_DECERR;
              waitreq_q <= 1'b0;
              state_q   <= ST_DONE;
            end
          end
        end

        ST_ACCESS: begin
          if (!sel_wait) begin
            rdata_q     <= is_write_q ? 32'd0 : sel_rdata;
            resp_q      <= sel_resp;
            rd_strobe_q <= '0;
            wr_strobe_q <= '0;
            waitreq_q   <= 1'b0;
            state_q     <= ST_DONE;
          end else if (cnt_q >= TIMEOUT_LIM) begin
            // cnt_q counts ACCESS cycles from 1, so the strobe has been
            // visible for exactly TIMEOUT_CYCLES cycles at this point.
            rdata_q     <= '0;
            resp_q      <= RESP_SLVERR;
            rd_strobe_q <= '0;
            wr_strobe_q <= '0;
            waitreq_q   <= 1'b0;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        ST_DONE: begin
          waitreq_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ST_IDLE;
        end

        default: begin
          rd_strobe_q <= '0;
          wr_strobe_q <= '0;
          waitreq_q   <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_bus_read        = rd_strobe_q;
  assign m_bus_write       = wr_strobe_q;
  assign s_bus_waitrequest = waitreq_q;
  assign s_bus_readdata    = rdata_q;
  assign s_bus_response    = resp_q;

endmodule

// File: tb/tb_interconnect_nport.sv
// -----------------------------------------------------------------------------
// tb_interconnect_nport
//
// Directed bench for interconnect_nport. Instance dut_a uses the default
// address map. Instance dut_b widens port 0's mask so that ports 0 and 2
// overlap. Both instances share the upstream and downstream inputs. Outputs
// are sampled on the falling edge; inputs change on the falling edge as well.
// -----------------------------------------------------------------------------
module tb_interconnect_nport;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  s_addr;
  logic         s_read;
  logic         s_write;
  logic [31:0]  s_wdata;
  logic [3:0]   s_be;
  logic [127:0] m_rdata;
  logic [7:0]   m_resp;
  logic [3:0]   m_wait;

  logic [31:0]  s_rdata_a, s_rdata_b;
  logic [1:0]   s_resp_a, s_resp_b;
  logic         s_wait_a, s_wait_b;
  logic [127:0] m_addr_a, m_addr_b;
  logic [3:0]   m_read_a, m_read_b;
  logic [3:0]   m_write_a, m_write_b;
  logic [127:0] m_wdata_a, m_wdata_b;
  logic [15:0]  m_be_a, m_be_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  interconnect_nport dut_a (
    .clk(clk), .rst(rst),
    .s_bus_addr(s_addr), .s_bus_read(s_read), .s_bus_write(s_write),
    .s_bus_writedata(s_wdata), .s_bus_byteenable(s_be),
    .s_bus_readdata(s_rdata_a), .s_bus_response(s_resp_a),
    .s_bus_waitrequest(s_wait_a),
    .m_bus_addr(m_addr_a), .m_bus_read(m_read_a), .m_bus_write(m_write_a),
    .m_bus_writedata(m_wdata_a), .m_bus_byteenable(m_be_a),
    .m_bus_readdata(m_rdata), .m_bus_response(m_resp),
    .m_bus_waitrequest(m_wait)
  );

  interconnect_nport #(
    .MASK_LIST({32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F000})
  ) dut_b (
    .clk(clk), .rst(rst),
    .s_bus_addr(s_addr), .s_bus_read(s_read), .s_bus_write(s_write),
    .s_bus_writedata(s_wdata), .s_bus_byteenable(s_be),
    .s_bus_readdata(s_rdata_b), .s_bus_response(s_resp_b),
    .s_bus_waitrequest(s_wait_b),
    .m_bus_addr(m_addr_b), .m_bus_read(m_read_b), .m_bus_write(m_write_b),
    .m_bus_writedata(m_wdata_b), .m_bus_byteenable(m_be_b),
    .m_bus_readdata(m_rdata), .m_bus_response(m_resp),
    .m_bus_waitrequest(m_wait)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    s_read  = 1'b0;
    s_write = 1'b0;
  endtask

  initial begin
    int strobe_cnt;
    int done_k;
    logic [31:0] cap_rdata;
    logic [1:0]  cap_resp;

    rst     = 1'b1;
    s_addr  = '0;
    s_read  = 1'b0;
    s_write = 1'b0;
    s_wdata = '0;
    s_be    = '0;
    m_rdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'hA5A5_0001};
    m_resp  = 8'b00_00_00_01;   // port0 returns 01, others 00
    m_wait  = 4'h0;

    // ---------------- reset state ----------------
    @(negedge clk);
    chk("rst_wait",  32'(s_wait_a),  32'd1);
    chk("rst_read",  32'(m_read_a),  32'd0);
    chk("rst_write", 32'(m_write_a), 32'd0);
    chk("rst_rdata", s_rdata_a,      32'd0);
    chk("rst_resp",  32'(s_resp_a),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- read 0x104, port1, no wait ----------------
    s_addr = 32'h0000_0104; s_read = 1'b1;
    @(negedge clk);  // ACCESS
    chk("rd1_strobe", 32'(m_read_a), 32'h2);
    chk("rd1_addr1",  m_addr_a[63:32], 32'h04);
    chk("rd1_wait_c2", 32'(s_wait_a), 32'd1);
    @(negedge clk);  // DONE (cycle 3)
    chk("rd1_wait_c3", 32'(s_wait_a), 32'd0);
    chk("rd1_rdata",  s_rdata_a, 32'hDEAD_BEEF);
    chk("rd1_resp",   32'(s_resp_a), 32'd0);
    chk("rd1_strobe_off", 32'(m_read_a), 32'd0);
    idle_inputs();
    @(negedge clk);  // IDLE
    chk("rd1_wait_back", 32'(s_wait_a), 32'd1);
    chk("rd1_hold", s_rdata_a, 32'hDEAD_BEEF);

    // ---------------- decode miss 0x500 ----------------
    s_addr = 32'h0000_0500; s_read = 1'b1;
    @(negedge clk);  // DONE at cycle 2
    chk("dec_wait",   32'(s_wait_a), 32'd0);
    chk("dec_resp",   32'(s_resp_a), 32'h3);
    chk("dec_rdata",  s_rdata_a, 32'd0);
    chk("dec_strobe", 32'(m_read_a), 32'd0);
    idle_inputs();
    @(negedge clk);

    // ---------------- read 0x010, port0, downstream resp 01 ----------------
    s_addr = 32'h0000_0010; s_read = 1'b1;
    @(negedge clk);
    chk("rd0_strobe", 32'(m_read_a), 32'h1);
    chk("rd0_addr0",  m_addr_a[31:0], 32'h10);
    @(negedge clk);
    chk("rd0_rdata", s_rdata_a, 32'hA5A5_0001);
    chk("rd0_resp",  32'(s_resp_a), 32'h1);
    idle_inputs();
    @(negedge clk);

    // ---------------- write 0x208, port2 waits 4 cycles ----------------
    s_addr = 32'h0000_0208; s_wdata = 32'h1234_5678; s_be = 4'b0011; s_write = 1'b1;
    m_wait = 4'b0100;
    strobe_cnt = 0; done_k = 0; cap_rdata = 32'hFFFF_FFFF; cap_resp = 2'b11;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("wr_addr2",  m_addr_a[95:64], 32'h08);
        chk("wr_wdata2", m_wdata_a[95:64], 32'h1234_5678);
        chk("wr_be2",    32'(m_be_a[11:8]), 32'h3);
        chk("wr_strobe", 32'(m_write_a), 32'h4);
      end
      if (m_write_a == 4'b0100) strobe_cnt++;
      if (!s_wait_a && done_k == 0) begin
        done_k = k; cap_rdata = s_rdata_a; cap_resp = s_resp_a;
        idle_inputs();
      end
      if (k == 5) m_wait = 4'h0;
    end
    chk("wr_strobe_cycles", 32'(strobe_cnt), 32'd5);
    chk("wr_done_cycle",    32'(done_k), 32'd6);
    chk("wr_rdata",         cap_rdata, 32'd0);
    chk("wr_resp",          32'(cap_resp), 32'd0);

    // ---------------- timeout on port3 ----------------
    s_addr = 32'h0000_030C; s_read = 1'b1;
    m_wait = 4'hF;
    strobe_cnt = 0; done_k = 0; cap_rdata = 32'hFFFF_FFFF; cap_resp = 2'b00;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (m_read_a == 4'b1000) strobe_cnt++;
      if (!s_wait_a && done_k == 0) begin
        done_k = k; cap_rdata = s_rdata_a; cap_resp = s_resp_a;
        idle_inputs();
      end
    end
    chk("to_strobe_cycles", 32'(strobe_cnt), 32'd16);
    chk("to_done_cycle",    32'(done_k), 32'd17);
    chk("to_resp",          32'(cap_resp), 32'h2);
    chk("to_rdata",         cap_rdata, 32'd0);
    m_wait = 4'h0;
    @(negedge clk);

    // ---------------- overlapping windows ----------------
    s_addr = 32'h0000_0210; s_read = 1'b1;
    @(negedge clk);
    chk("ovl_a_strobe", 32'(m_read_a), 32'h4);
    chk("ovl_b_strobe", 32'(m_read_b), 32'h1);
    chk("ovl_b_addr0",  m_addr_b[31:0], 32'h210);
    @(negedge clk);
    chk("ovl_b_rdata", s_rdata_b, 32'hA5A5_0001);
    chk("ovl_a_rdata", s_rdata_a, 32'h2222_2222);
    idle_inputs();
    @(negedge clk);

    // ---------------- read and write together ----------------
    s_addr = 32'h0000_0104; s_read = 1'b1; s_write = 1'b1;
    @(negedge clk);
    chk("rw_read",  32'(m_read_a), 32'd0);
    chk("rw_write", 32'(m_write_a), 32'd0);
    chk("rw_wait",  32'(s_wait_a), 32'd0);
    chk("rw_resp",  32'(s_resp_a), 32'h2);
    chk("rw_rdata", s_rdata_a, 32'd0);
    idle_inputs();
    @(negedge clk);

    // ---------------- reset during ACCESS cycle 2 ----------------
    s_addr = 32'h0000_0104; s_read = 1'b1; m_wait = 4'hF;
    @(negedge clk);
    chk("mr_strobe_c1", 32'(m_read_a), 32'h2);
    @(negedge clk);
    chk("mr_strobe_c2", 32'(m_read_a), 32'h2);
    #1 rst = 1'b1;
    #1;
    chk("mr_async_strobe", 32'(m_read_a), 32'd0);
    chk("mr_async_wait",   32'(s_wait_a), 32'd1);
    chk("mr_async_resp",   32'(s_resp_a), 32'd0);
    idle_inputs();
    m_wait = 4'h0;
    @(negedge clk);
    chk("mr_no_done", 32'(s_wait_a), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    s_addr = 32'h0000_0104; s_read = 1'b1;
    @(negedge clk);
    chk("mr2_wait_c2", 32'(s_wait_a), 32'd1);
    chk("mr2_strobe",  32'(m_read_a), 32'h2);
    @(negedge clk);
    chk("mr2_wait_c3", 32'(s_wait_a), 32'd0);
    chk("mr2_rdata",   s_rdata_a, 32'hDEAD_BEEF);
    idle_inputs();
    @(negedge clk);
    chk("mr2_idle", 32'(s_wait_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
